// File: rtl/logic_bist_ctrl_if.sv
// Signal bundle between the BIST controller and the cell-under-test harness.
// Handshake: start is a one-cycle request honoured only when busy=0; done stays high until the next accepted start.
interface logic_bist_ctrl_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1
);
  logic             start;
  logic [N_IN-1:0]  vec_out;
  logic [N_OUT-1:0] y_dut;
  logic [N_OUT-1:0] y_ref;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_IN:0]    pass_cnt;
  logic [N_IN:0]    fail_cnt;
  logic             first_fail_valid;
  logic [N_IN-1:0]  first_fail_vec;
  logic [1:0]       state_dbg;

  modport master (
    output start, y_dut, y_ref,
    input  vec_out, busy, done, pass, pass_cnt, fail_cnt,
           first_fail_valid, first_fail_vec, state_dbg
  );

  modport slave (
    input  start, y_dut, y_ref,
    output vec_out, busy, done, pass, pass_cnt, fail_cnt,
           first_fail_valid, first_fail_vec, state_dbg
  );
endinterface

// File: rtl/logic_bist_ctrl.sv
// Exhaustive self-test engine for small combinational cells: walks every input
// vector, compares DUT against reference, counts results and latches the first failure.
module logic_bist_ctrl #(
  parameter int N_IN       = 3,
  parameter int N_OUT      = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_bist_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0]   SETTLE_LOAD = SW'(SETTLE_CYC - 1);
  localparam logic [SW-1:0]   SETTLE_ONE  = SW'(1);
  localparam logic [N_IN-1:0] LAST_VEC    = '1;
  localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE     = (N_IN+1)'(1);

  logic [1:0]      state;
  logic [SW-1:0]   settle_cnt;
  logic [N_IN-1:0] vec;
  logic [N_IN:0]   pass_cnt;
  logic [N_IN:0]   fail_cnt;
  logic            ff_valid;
  logic [N_IN-1:0] ff_vec;
  logic            mismatch;
  logic            start_ok;

  assign mismatch = (bus.y_dut != bus.y_ref);
  // A start pulse arriving mid-run is simply dropped.
  assign start_ok = bus.start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      vec        <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      ff_valid   <= 1'b0;
      ff_vec     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state      <= SETTLE;
            settle_cnt <= SETTLE_LOAD;
            vec        <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            ff_valid   <= 1'b0;
            ff_vec     <= '0;
          end
        end
        SETTLE: begin
          // The cycle that observes zero is the last hold cycle, so each
          // vector is held SETTLE_CYC cycles before its CHECK cycle.
          if (settle_cnt == '0) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - SETTLE_ONE;
          end
        end
        CHECK: begin
          if (mismatch) begin
            fail_cnt <= fail_cnt + CNT_ONE;
            if (!ff_valid) begin
              ff_valid <= 1'b1;
              ff_vec   <= vec;
            end
          end else begin
            pass_cnt <= pass_cnt + CNT_ONE;
          end
          if (vec == LAST_VEC) begin
            state <= DONE;
          end else begin
            vec        <= vec + VEC_ONE;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.vec_out          = vec;
  assign bus.busy             = (state == SETTLE) || (state == CHECK);
  assign bus.done             = (state == DONE);
  assign bus.pass             = (state == DONE) && (fail_cnt == '0);
  assign bus.pass_cnt         = pass_cnt;
  assign bus.fail_cnt         = fail_cnt;
  assign bus.first_fail_valid = ff_valid;
  assign bus.first_fail_vec   = ff_vec;
  assign bus.state_dbg        = state;

endmodule

// File: doc/logic_bist_ctrl.md
Name: logic_bist_ctrl

Overview:
Synthesizable self-test engine for small combinational cells such as the and3/or3/xor gate family. It drives every input vector of the cell under test in ascending order and compares the DUT output against a golden reference output. It accumulates pass/fail counts and latches the first failing vector. It is the on-chip responder to the vector-driving testbenches, placed beside each gate wrapper so the same exhaustive check runs in silicon and in FPGA bring-up.

Parameters:
N_IN, 3, number of DUT inputs; 2^N_IN vectors per run (1..8).
N_OUT, 1, number of DUT outputs compared (1..8).
SETTLE_CYC, 2, cycles a vector is held before comparison (>=1).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk.
start  input  1  single-cycle pulse that begins a run; sampled only in IDLE or DONE.
vec_out  output  N_IN  stimulus to DUT and reference; bit0 = first input (a), bit1 = b, bit2 = c, and so on.
y_dut  input  N_OUT  DUT output.
y_ref  input  N_OUT  reference model output.
busy  output  1  high while a run is in progress.
done  output  1  high from run completion until the next start or reset.
pass  output  1  valid when done=1; equals (fail_cnt == 0).
pass_cnt  output  N_IN+1  number of matching vectors.
fail_cnt  output  N_IN+1  number of mismatching vectors.
first_fail_valid  output  1  set on the first mismatch of a run.
first_fail_vec  output  N_IN  vec_out value at the first mismatch.

Behaviour:
- Reset value of every output is 0; the FSM is in IDLE.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE, start=1: clear both counters, first_fail_valid and first_fail_vec; set vec_out=0; load settle counter = SETTLE_CYC-1; busy=1; go to SETTLE.
- SETTLE: decrement the settle counter each cycle; when it reaches 0, go to CHECK. A vector is therefore held SETTLE_CYC cycles before its CHECK cycle.
- CHECK (one cycle): sample y_dut and y_ref at that clock edge.
  - Match (all N_OUT bits equal): pass_cnt += 1.
  - Mismatch (any bit differs): fail_cnt += 1. If first_fail_valid=0, set first_fail_valid=1 and first_fail_vec=vec_out.
  - If vec_out == 2^N_IN-1: go to DONE.
  - Otherwise: vec_out += 1, reload the settle counter, go to SETTLE.
- Timing: each vector occupies SETTLE_CYC+1 cycles. A run takes 2^N_IN*(SETTLE_CYC+1) cycles from the start edge to the done rising edge. done, pass and busy=0 update on the same edge as the final CHECK.
- DONE: vec_out holds 2^N_IN-1; counters and first-fail fields hold. start=1 restarts exactly as from IDLE, clearing all results.
- start while busy=1 is ignored; there is no queuing.
- vec_out increments within N_IN bits. The final vector never wraps because the FSM exits to DONE first.
- Counters are N_IN+1 bits wide and saturate-free by construction; the maximum value is 2^N_IN.
- Invariant: pass_cnt + fail_cnt == number of CHECK cycles completed in the current run.
- rst_n low at any time, including mid-run: all outputs go to 0 immediately and the FSM returns to IDLE. Results of the partial run are discarded.
- The comparison is a plain bitwise inequality; the bench must not drive X/Z on y_dut or y_ref.

Test Plan:
1. Reset check: hold rst_n=0 -> busy=done=pass=0, vec_out=0, pass_cnt=fail_cnt=0, first_fail_valid=0.
2. Good DUT (N_IN=3, SETTLE_CYC=2, y_dut=y_ref=a&b&c), pulse start -> busy for exactly 24 cycles, vec_out steps 0..7 every 3 cycles. Then done=1, pass=1, pass_cnt=8, fail_cnt=0, first_fail_valid=0.
3. DUT stuck-at-0 versus 3-input AND reference -> done after 24 cycles with pass=0, pass_cnt=7, fail_cnt=1, first_fail_vec=3'b111.
4. DUT = a|b|c versus 3-input AND reference -> fail_cnt=6 (vectors 1..6), pass_cnt=2, first_fail_vec=3'b001, pass=0.
5. Extra start pulses at cycles 5 and 12 of a run -> ignored; completion still at cycle 24 with unchanged counts. Then rst_n=0 at cycle 10 of a new run -> all outputs 0 asynchronously. A fresh start afterwards completes normally.
6. From DONE with fail_cnt=1, pulse start with a good DUT -> counters and first_fail_valid clear on the start edge; the run ends with pass=1, pass_cnt=8.
